prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64, total configuration bits in the downstream prog_in/prog_out shift chain (range 2..65535).
REQ-002 Parameter W, default 8, configuration word width (range 2..32).
REQ-003 prog_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 prog_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin a configuration session; sampled only in IDLE or DONE.
REQ-006 verify_en  input  1  request readback check; sampled in the cycle start is accepted.
REQ-007 abort  input  1  terminate any session; returns to IDLE.
REQ-008 cfg_data  input  W  configuration word, MSB shifted first.
REQ-009 cfg_valid  input  1  cfg_data valid.
REQ-010 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-011 prog_in  output  1  serial bit to chain head.
REQ-012 prog_en  output  1  chain shift enable; high only in cycles carrying a real bit.
REQ-013 prog_out  input  1  serial bit from chain tail.
REQ-014 busy  output  1  high in LOAD and VERIFY.
REQ-015 done  output  1  level, high in DONE.
REQ-016 error  output  1  level, readback CRC mismatch; valid while done=1.
REQ-017 crc  output  8  CRC-8 of the bits loaded in the current/last session.

Function
REQ-018 States: IDLE, LOAD, VERIFY, DONE; IDLE->LOAD on start; DONE->LOAD on start; any state->IDLE on abort (abort has priority over start).
REQ-019 Entering LOAD: bit counter, word buffer, crc and error all cleared to 0 in the same edge.
REQ-020 Word transfer occurs on a cycle with cfg_valid=1 and cfg_ready=1; nothing is consumed otherwise.
REQ-021 cfg_ready=1 only in LOAD, when the buffer holds 0 or 1 unshifted bits and bits still owed to the chain exceed the buffered count; combinational from state, not from cfg_valid.
REQ-022 Word accepted at edge t: its bits appear on prog_in with prog_en=1 in cycles t+1..t+k, MSB first, k = min(W, bits remaining); back-to-back words give gapless prog_en.
REQ-023 Buffer empty with bits still owed: prog_en=0, prog_in=0 (bubble); chain content is not disturbed.
REQ-024 Exactly CHAIN_LEN prog_en=1 cycles per LOAD; unused low bits of the final word are discarded, not shifted.
REQ-025 Every bit shifted in LOAD updates crc: fb=crc[7]^bit; crc <= {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00); init 8'h00.
REQ-026 After the CHAIN_LEN-th LOAD bit: go to VERIFY if verify_en was latched, else DONE.
REQ-027 VERIFY: prog_en=1 for exactly CHAIN_LEN consecutive cycles with prog_in=prog_out (recirculate, chain restored); second CRC over sampled prog_out bits, same polynomial, init 0.
REQ-028 End of VERIFY: error <= (verify CRC != crc); state -> DONE; crc output keeps LOAD value.
REQ-029 start, cfg_valid in LOAD/VERIFY other than per REQ-020 are ignored; cfg_valid in IDLE/DONE is ignored.
REQ-030 abort mid-LOAD/VERIFY: prog_en=0 from the next cycle, buffered bits discarded, done=0, error=0; chain contents undefined.

Reset
REQ-031 prog_rst_n=0 immediately forces IDLE, prog_en=0, prog_in=0, cfg_ready=0, busy=0, done=0, error=0, crc=8'h00, counters 0.
REQ-032 First session after reset release requires start; no action otherwise.

Verification
REQ-033 CHAIN_LEN=12, W=8, words 0xA5,0x3C, verify_en=0 -> prog_in bits 1010_0101_0011, prog_en high exactly 12 cycles, 2 words consumed, done=1, crc equals bit-serial model.
REQ-034 Same load, verify_en=1, behavioural 12-bit chain model -> 12 recirculate cycles, error=0, chain content unchanged afterwards.
REQ-035 Same as REQ-034 with prog_out stuck at 0 -> error=1, done=1.
REQ-036 cfg_valid toggling 1-of-3 cycles, CHAIN_LEN=64, W=8 -> 8 words consumed, 64 prog_en cycles, bubbles have prog_en=0, crc matches model.
REQ-037 abort after 5 LOAD bits, then start with new data -> prog_en low next cycle, state IDLE, new session crc starts from 0 and matches model of new data only.
REQ-038 prog_rst_n pulsed low mid-VERIFY -> all outputs at reset values asynchronously; no further prog_en until next start.

Source files
------------

// File: rtl/prog_loader.sv
// Serial configuration loader: accepts W-bit words on a valid/ready port,
// shifts CHAIN_LEN bits MSB-first into a downstream shift chain while
// accumulating a CRC-8, and optionally recirculates the chain once to
// re-check it against that CRC.
module prog_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned W         = 8
) (
  input  logic         prog_clk,
  input  logic         prog_rst_n,
  input  logic         start,
  input  logic         verify_en,
  input  logic         abort,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  output logic         prog_in,
  output logic         prog_en,
  input  logic         prog_out,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [7:0]   crc
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned XW = (CW > BW) ? CW : BW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [BW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      vcrc_q, vcrc_d;
  logic            error_q, error_d;
  logic            verify_q, verify_d;

  logic [XW-1:0]   owed, bufc, owed_next;
  logic            shift, last_bit;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // State register and datapath flops
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      buf_q     <= '0;
      buf_cnt_q <= '0;
      crc_q     <= '0;
      vcrc_q    <= '0;
      error_q   <= 1'b0;
      verify_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      buf_q     <= buf_d;
      buf_cnt_q <= buf_cnt_d;
      crc_q     <= crc_d;
      vcrc_q    <= vcrc_d;
      error_q   <= error_d;
      verify_q  <= verify_d;
    end
  end

  // Next-state, word buffering, shift-out and CRC accumulation
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    crc_d     = crc_q;
    vcrc_d    = vcrc_q;
    error_d   = error_q;
    verify_d  = verify_q;
    prog_en   = 1'b0;
    prog_in   = 1'b0;
    shift     = 1'b0;
    owed_next = '0;

    owed      = XW'(CHAIN_LEN) - XW'(bit_cnt_q);
    bufc      = XW'(buf_cnt_q);
    last_bit  = (bit_cnt_q == CW'(CHAIN_LEN - 1));
    cfg_ready = (state_q == S_LOAD) && (buf_cnt_q <= BW'(1)) && (owed > bufc);

    case (state_q)
      S_LOAD: begin
        shift = (buf_cnt_q != '0);
        if (shift) begin
          prog_en   = 1'b1;
          prog_in   = buf_q[W-1];
          crc_d     = crc_step(crc_q, buf_q[W-1]);
          bit_cnt_d = bit_cnt_q + CW'(1);
          buf_d     = buf_q << 1;
          buf_cnt_d = buf_cnt_q - BW'(1);
        end
        // A new word may land in the same edge that shifts out the last
        // buffered bit, keeping prog_en gapless across words.
        if (cfg_ready && cfg_valid) begin
          owed_next = owed - XW'(shift);
          buf_d     = cfg_data;
          buf_cnt_d = (owed_next >= XW'(W)) ? BW'(W) : BW'(owed_next);
        end
        if (shift && last_bit) begin
          bit_cnt_d = '0;
          buf_cnt_d = '0;
          state_d   = verify_q ? S_VERIFY : S_DONE;
        end
      end
      S_VERIFY: begin
        prog_en   = 1'b1;
        prog_in   = prog_out;
        vcrc_d    = crc_step(vcrc_q, prog_out);
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (last_bit) begin
          error_d   = (vcrc_d != crc_q);
          bit_cnt_d = '0;
          state_d   = S_DONE;
        end
      end
      default: begin
        if (start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          buf_d     = '0;
          buf_cnt_d = '0;
          crc_d     = '0;
          vcrc_d    = '0;
          error_d   = 1'b0;
          verify_d  = verify_en;
        end
      end
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      buf_d     = '0;
      buf_cnt_d = '0;
      error_d   = 1'b0;
    end
  end

  assign busy  = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done  = (state_q == S_DONE);
  assign error = error_q;
  assign crc   = crc_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int unsigned W = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start12 = 1'b0, start64 = 1'b0, verify_en = 1'b0, abort = 1'b0;
  logic cfg_valid = 1'b0, stuck = 1'b0, sel = 1'b0;
  logic [W-1:0] cfg_data = '0;

  logic rdy12, in12, en12, busy12, done12, err12, po12;
  logic rdy64, in64, en64, busy64, done64, err64, po64;
  logic [7:0] crc12, crc64;
  logic [11:0] chain12 = '0;
  logic [63:0] chain64 = '0;
  logic s_en12 = 1'b0, s_in12 = 1'b0, s_en64 = 1'b0, s_in64 = 1'b0;

  logic rdy_c, in_c, en_c, busy_c, done_c, err_c;
  logic [7:0] crc_c;

  int unsigned checks = 0, errors = 0;
  bit q_bits[$];
  int unsigned wcount = 0, viol = 0;
  logic acc = 1'b0;

  always #5 clk = ~clk;

  assign po12 = stuck ? 1'b0 : chain12[11];
  assign po64 = stuck ? 1'b0 : chain64[63];

  prog_loader #(.CHAIN_LEN(12), .W(W)) u_dut12 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start12), .verify_en(verify_en),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy12),
    .prog_in(in12), .prog_en(en12), .prog_out(po12), .busy(busy12), .done(done12),
    .error(err12), .crc(crc12));

  prog_loader #(.CHAIN_LEN(64), .W(W)) u_dut64 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start64), .verify_en(verify_en),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy64),
    .prog_in(in64), .prog_en(en64), .prog_out(po64), .busy(busy64), .done(done64),
    .error(err64), .crc(crc64));

  always_comb begin
    rdy_c  = sel ? rdy64  : rdy12;
    in_c   = sel ? in64   : in12;
    en_c   = sel ? en64   : en12;
    busy_c = sel ? busy64 : busy12;
    done_c = sel ? done64 : done12;
    err_c  = sel ? err64  : err12;
    crc_c  = sel ? crc64  : crc12;
  end

  // Mid-cycle monitor of the selected loader plus samples for the chain models
  always @(negedge clk) begin
    s_en12 = en12; s_in12 = in12; s_en64 = en64; s_in64 = in64;
    acc = 1'b0;
    if (rst_n) begin
      if (en_c) q_bits.push_back(in_c);
      if (!en_c && in_c) viol++;
      if (rdy_c && !busy_c) viol++;
      if (cfg_valid && rdy_c) begin wcount++; acc = 1'b1; end
    end
  end

  // Behavioural downstream chains: head at bit 0, tail at the MSB
  always @(posedge clk) begin
    if (rst_n) begin
      if (s_en12) chain12 <= {chain12[10:0], s_in12};
      if (s_en64) chain64 <= {chain64[62:0], s_in64};
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: bits are the word stream read MSB-first, truncated to n bits
  function automatic logic [7:0] crc_of(input logic [63:0] w, input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ w[63-i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  // stop_kind: 0 run to done, 1 abort after stop_at bits, 2 reset after stop_at bits
  task automatic run_session(input string nm, input bit s, input bit v, input bit stk,
                             input int mode, input logic [63:0] w, input bit exp_err,
                             input logic [7:0] exp_crc, input int stop_kind, input int stop_at);
    int n, idx, cyc, n0;
    bit fin;
    logic [63:0] m, lv, vv;
    n = s ? 64 : 12;
    sel = s; stuck = stk;
    q_bits.delete(); wcount = 0; viol = 0; idx = 0; cyc = 0; fin = 0;
    @(posedge clk); #1;
    start12 = !s; start64 = s; verify_en = v;
    @(posedge clk); #1;
    start12 = 1'b0; start64 = 1'b0;
    while (!fin && cyc < 2000) begin
      cfg_data  = (idx < 8) ? w[63-8*idx -: 8] : 8'($urandom);
      cfg_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      verify_en = 1'($urandom_range(0, 1));
      if (s) start64 = ($urandom_range(0, 7) == 0); else start12 = ($urandom_range(0, 7) == 0);
      @(negedge clk); #1;
      if (stop_kind == 0 && done_c) fin = 1;
      else if (stop_kind != 0 && q_bits.size() >= stop_at) fin = 1;
      else begin
        @(posedge clk); #1;
        if (acc) idx++;
      end
      cyc++;
    end
    start12 = 1'b0; start64 = 1'b0; verify_en = 1'b0; cfg_valid = 1'b0;
    check({nm, " completes"}, 64'(fin), 64'd1);
    if (stop_kind == 1) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check({nm, " abort prog_en"}, 64'(en_c), 64'd0);
      check({nm, " abort busy"}, 64'(busy_c), 64'd0);
      check({nm, " abort done"}, 64'(done_c), 64'd0);
      check({nm, " abort error"}, 64'(err_c), 64'd0);
      repeat (3) @(negedge clk);
      #1 check({nm, " abort bit count"}, 64'(q_bits.size()), 64'(stop_at));
    end else if (stop_kind == 2) begin
      rst_n = 1'b0;
      #1;
      check({nm, " rst prog_en"}, 64'(en_c), 64'd0);
      check({nm, " rst prog_in"}, 64'(in_c), 64'd0);
      check({nm, " rst flags"}, {60'd0, rdy_c, busy_c, done_c, err_c}, 64'd0);
      check({nm, " rst crc"}, 64'(crc_c), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst_n = 1'b1;
      n0 = q_bits.size();
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_data  = 8'($urandom);
        verify_en = 1'($urandom_range(0, 1));
      end
      cfg_valid = 1'b0;
      @(negedge clk); #1;
      check({nm, " post-rst no shift"}, 64'(q_bits.size()), 64'(n0));
      check({nm, " post-rst idle"}, {62'd0, busy_c, done_c}, 64'd0);
    end else begin
      m  = ~({64{1'b1}} >> n);
      lv = '0; vv = '0;
      for (int i = 0; i < n; i++) begin
        if (i < q_bits.size()) lv[63-i] = q_bits[i];
        if (n + i < q_bits.size()) vv[63-i] = q_bits[n+i];
      end
      check({nm, " done"}, 64'(done_c), 64'd1);
      check({nm, " busy"}, 64'(busy_c), 64'd0);
      check({nm, " prog_en cycles"}, 64'(q_bits.size()), 64'(v ? 2 * n : n));
      check({nm, " load bits"}, lv, w & m);
      check({nm, " words"}, 64'(wcount), 64'((n + W - 1) / W));
      check({nm, " crc"}, 64'(crc_c), 64'(exp_crc));
      check({nm, " error"}, 64'(err_c), 64'(exp_err));
      check({nm, " bubbles"}, 64'(viol), 64'd0);
      if (v) check({nm, " verify bits"}, vv, stk ? 64'd0 : (w & m));
      if (v && !stk) check({nm, " chain kept"}, s ? chain64 : {52'd0, chain12}, s ? w : {52'd0, w[63:52]});
    end
  endtask

  typedef struct {
    string       nm;
    bit          s;
    bit          v;
    bit          stk;
    int          mode;
    logic [63:0] w;
    bit          err;
    logic [7:0]  crc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [63:0] w12, rw;
    bit rs, rv, rk;
    w12 = {8'hA5, 8'h3C, 32'($urandom), 16'($urandom)};
    tbl[0] = '{"l12", 0, 0, 0, 0, w12, 0, 8'h3C};
    tbl[1] = '{"l12v", 0, 1, 0, 0, w12, 0, 8'h3C};
    tbl[2] = '{"l12stuck", 0, 1, 1, 0, w12, 1, 8'h3C};
    for (int i = 3; i < 7; i++) begin
      rw = {32'($urandom), 32'($urandom)};
      tbl[i] = '{"tbl", (i != 5), (i != 3), (i == 6), (i == 4) ? 2 : ((i == 6) ? 0 : 1), rw, 0, 8'h00};
      tbl[i].crc = crc_of(rw, tbl[i].s ? 64 : 12);
      tbl[i].err = tbl[i].v && tbl[i].stk && (tbl[i].crc != 8'h00);
    end

    #3;
    check("reset 12", {56'd0, rdy12, in12, en12, busy12, done12, err12, 2'b00}, 64'd0);
    check("reset 64", {56'd0, rdy64, in64, en64, busy64, done64, err64, 2'b00}, 64'd0);
    check("reset crc", {48'd0, crc12, crc64}, 64'd0);
    #20 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_data = 8'($urandom);
    end
    cfg_valid = 1'b0;
    @(negedge clk); #1;
    check("idle without start", {60'd0, busy12, busy64, en12, en64}, 64'd0);

    for (int i = 0; i < 7; i++)
      run_session(tbl[i].nm, tbl[i].s, tbl[i].v, tbl[i].stk, tbl[i].mode, tbl[i].w,
                  tbl[i].err, tbl[i].crc, 0, 0);

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1)); rv = 1'($urandom_range(0, 1)); rk = 1'($urandom_range(0, 1));
      rw = {32'($urandom), 32'($urandom)};
      run_session("rand", rs, rv, rk, int'($urandom_range(0, 2)), rw,
                  rv && rk && (crc_of(rw, rs ? 64 : 12) != 8'h00), crc_of(rw, rs ? 64 : 12), 0, 0);
    end

    run_session("abort", 0, 0, 0, 0, w12, 0, 8'h00, 1, 5);
    rw = {32'($urandom), 32'($urandom)};
    run_session("after abort", 0, 0, 0, 2, rw, 0, crc_of(rw, 12), 0, 0);

    run_session("rst verify", 0, 1, 0, 0, w12, 0, 8'h00, 2, 15);
    rw = {32'($urandom), 32'($urandom)};
    run_session("after rst", 1, 1, 0, 0, rw, 0, crc_of(rw, 64), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
